// File: rtl/restoring_divider_8.sv
// Restoring unsigned divider: one quotient bit per clock through a
// three-state IDLE/CALC/DONE controller, with registered results that
// persist until the next operation completes.
module restoring_divider_8 #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // The partial remainder A is always below M between steps, so its top
  // bit is provably zero and only WIDTH bits need to be stored; the extra
  // bit exists only transiently in the shifted/trial values.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_divByZero;

  logic [WIDTH:0]   w_shiftA;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_shiftQ;
  logic [WIDTH-1:0] w_stepA;
  logic [WIDTH-1:0] w_stepQ;
  logic             w_lastStep;
  logic             w_startCalc;
  logic             w_startZero;

  assign w_startCalc = Run && (Divisor != '0);
  assign w_startZero = Run && (Divisor == '0);
  assign w_lastStep  = (r_count == LAST_STEP);

  assign w_shiftA = {r_a, r_q[WIDTH-1]};
  assign w_shiftQ = {r_q[WIDTH-2:0], 1'b0};
  assign w_trial  = w_shiftA - {1'b0, r_m};

  // State register; reset forces IDLE without waiting for a clock edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; DONE waits for Run to drop so one request gives one result.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_startZero) begin
          w_nextState = DONE;
        end else if (w_startCalc) begin
          w_nextState = CALC;
        end
      end
      CALC: begin
        if (w_lastStep) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (!Run) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs decoded purely from state so reset clears them immediately.
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (r_state)
      CALC:    Busy = 1'b1;
      DONE:    Done = 1'b1;
      default: begin
        Busy = 1'b0;
        Done = 1'b0;
      end
    endcase
  end

  // One restoring step: keep the trial difference when it did not borrow.
  always_comb begin
    w_stepA = w_shiftA[WIDTH-1:0];
    w_stepQ = w_shiftQ;
    if (!w_trial[WIDTH]) begin
      w_stepA    = w_trial[WIDTH-1:0];
      w_stepQ[0] = 1'b1;
    end
  end

  // Working registers: capture operands on start, iterate while in CALC.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_startCalc) begin
            r_a     <= '0;
            r_q     <= Dividend;
            r_m     <= Divisor;
            r_count <= '0;
          end
        end
        CALC: begin
          r_a     <= w_stepA;
          r_q     <= w_stepQ;
          r_count <= r_count + CW'(1);
        end
        default: begin
          r_a     <= r_a;
          r_q     <= r_q;
          r_m     <= r_m;
          r_count <= r_count;
        end
      endcase
    end
  end

  // Result registers only update on entry to DONE, so the previous result
  // stays visible through IDLE and the whole of the next CALC.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divByZero <= 1'b0;
    end else if (r_state == IDLE && w_startZero) begin
      r_quotient  <= '1;
      r_remainder <= Dividend;
      r_divByZero <= 1'b1;
    end else if (r_state == CALC && w_lastStep) begin
      r_quotient  <= w_stepQ;
      r_remainder <= w_stepA;
      r_divByZero <= 1'b0;
    end
  end

  assign Quotient  = r_quotient;
  assign Remainder = r_remainder;
  assign DivByZero = r_divByZero;

endmodule
